fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch controller that sequences the instruction ROM (imem). It owns the program counter and drives the ROM address. It buffers fetched words in a small queue toward decode using a valid/ready handshake. It applies branch/jump redirects and halts on misaligned targets or the ROM's unmapped-address sentinel.

Parameters:
RESET_PC, 32'h00400000, PC value loaded on reset; first fetch address.
DEPTH, 2, instruction queue entries (power of 2, >=2).
ERR_WORD, 32'hDEADBEEF, ROM read value that flags an unmapped address.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
fetch_en  in  1  enables fetching; low parks the block in IDLE.
imem_addr  out  32  ROM address; always equals the PC register.
imem_rdata  in  32  ROM read data; combinational, valid in the same cycle.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_pc  in  32  redirect target.
inst_valid  out  1  queue head holds a valid instruction.
inst_ready  in  1  decode accepts head this cycle.
inst  out  32  head instruction word.
inst_pc  out  32  head instruction address.
halted  out  1  block is in HALT.
err_code  out  2  0 none, 1 unmapped fetch, 2 misaligned redirect.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=IDLE, queue count=0, storage cleared to 0, halted=0, err_code=0. Resulting outputs: imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0. Reset overrides all other inputs, including mid-redirect.
- States: IDLE, RUN, HALT.
  - IDLE: no push. fetch_en=1 moves to RUN next cycle.
  - RUN: fetch_en=0 moves to IDLE; the queue still drains.
  - HALT: exited only by an aligned redirect or by reset.
- Push condition: state=RUN, no redirect this cycle, and space available. Space = count<DEPTH, or count==DEPTH with a pop this cycle.
  - On push: enqueue {pc, imem_rdata}; pc <= pc+4 (mod 2^32; 0xFFFFFFFC wraps to 0).
  - Fetch latency: a word is visible at inst one cycle after its address appears on imem_addr (queue empty case).
- Pop: inst_valid & inst_ready. Simultaneous push and pop at full or empty is legal; count is unchanged.
- Unmapped fetch: imem_rdata==ERR_WORD while a push would occur.
  - Word is not enqueued; pc holds.
  - Next state HALT, err_code=1, halted=1.
  - Entries already queued still drain normally.
- Redirect (redirect_valid=1) has priority over push and over the unmapped check, in any state.
  - Aligned target (redirect_pc[1:0]==0): queue flushed (count=0, no pop counted), pc<=redirect_pc, err_code=0. HALT/RUN go to RUN; IDLE stays IDLE. No push that cycle.
  - Misaligned target: queue flushed, pc holds, state=HALT, err_code=2.
- Pop and redirect in the same cycle: the pop is accepted by decode, but the queue ends empty.
- inst_valid is (count!=0). inst/inst_pc come from the head register, with no combinational path from imem_rdata.
- halted is registered: halted = (state==HALT).

Decomposition:
- fetch_pkg: state enum {IDLE, RUN, HALT}, err enum {ERR_NONE, ERR_UNMAPPED, ERR_MISALIGN}, default constants RESET_PC_DEF and ERR_WORD_DEF.
- One sub-module, fetch_fifo: parameterised DEPTH x 64-bit sync FIFO with push, pop, flush, count, full and empty. flush has priority over push and pop.
- fetch_ctrl holds the PC register, FSM and error logic.

Test Plan:
- Reset then fetch_en=1, inst_ready=1, ROM returns 32'h3e802403 @0x00400000 and 32'h3ec02483 @0x00400004 -> imem_addr steps 0x00400000, 0x00400004…; inst=32'h3e802403, inst_pc=0x00400000 one cycle after RUN entry, then one instruction per cycle.
- inst_ready=0 for 5 cycles in RUN -> count reaches DEPTH=2, pc frozen at 0x00400008, no entry lost. Raise ready -> words @0x00400000, 0x00400004 and 0x00400008 delivered in order.
- Full queue, redirect_valid=1, redirect_pc=0x00400000, with inst_ready=1 the same cycle -> next cycle inst_valid=0, imem_addr=0x00400000. Next word out is from 0x00400000; the stale entry is never presented.
- ROM returns 32'hDEADBEEF @0x00400020 with one older entry queued -> halted=1, err_code=1, imem_addr stays 0x00400020, queued entry drains, then inst_valid=0. Aligned redirect to 0x00400000 -> RUN, err_code=0.
- redirect_pc=0x00400006 -> queue flushed, halted=1, err_code=2, pc unchanged.
- rst asserted while queue is full and a redirect is pending -> next cycle imem_addr=0x00400000, inst_valid=0, halted=0, err_code=0, state IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNMAPPED = 2'd1,
        ERR_MISALIGN = 2'd2
    } err_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] ERR_WORD_DEF = 32'hDEAD_BEEF;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO carrying {pc, word} pairs toward decode.
// The head entry is read straight from storage registers; flush wins over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty     = (count_q == {CNT_W{1'b0}});
    assign full      = (count_q == CNT_W'(DEPTH));
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, sequences the instruction ROM and feeds decode
// through a small queue; handles redirects and halts on bad fetches.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] ERR_WORD = ERR_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        halted,
    output logic [1:0]  err_code
);
    state_e      state_q, state_d;
    err_e        err_q, err_d;
    logic [31:0] pc_q, pc_d;
    logic        halted_q;

    logic                     push_s;
    logic                     pop_s;
    logic                     space_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [$clog2(DEPTH):0]   fifo_count_s;
    logic [63:0]              head_s;

    assign pop_s      = inst_valid & inst_ready;
    assign space_s    = ~fifo_full_s | pop_s;
    assign inst_valid = ~fifo_empty_s;
    assign inst_pc    = head_s[63:32];
    assign inst       = head_s[31:0];
    assign imem_addr  = pc_q;
    assign halted     = halted_q;
    assign err_code   = err_q;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({pc_q, imem_rdata}),
        .rdata (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state, PC and error logic; a redirect overrides both push and the unmapped check
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        push_s  = 1'b0;
        if (redirect_valid) begin
            if (is_word_aligned(redirect_pc)) begin
                pc_d    = redirect_pc;
                err_d   = ERR_NONE;
                state_d = (state_q == IDLE) ? IDLE : RUN;
            end else begin
                state_d = HALT;
                err_d   = ERR_MISALIGN;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_en) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (space_s && (imem_rdata == ERR_WORD)) begin
                        state_d = HALT;
                        err_d   = ERR_UNMAPPED;
                    end else begin
                        if (space_s) begin
                            push_s = 1'b1;
                            pc_d   = pc_q + 32'd4;
                        end else begin
                            push_s = 1'b0;
                        end
                        if (!fetch_en) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control registers; halted mirrors the registered state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            err_q    <= ERR_NONE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            err_q    <= err_d;
            halted_q <= (state_d == HALT);
        end
    end

    logic unused_s;
    assign unused_s = ^fifo_count_s;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed plus randomized bench for fetch_ctrl against a queue-based reference model.
module tb_fetch_ctrl;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0040_0000;
    localparam logic [31:0] ERRW  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata, inst, inst_pc;
    logic        inst_valid, halted;
    logic [1:0]  err_code;
    logic [31:0] err_addr = 32'h0000_0001;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    int          m_st;   // 0 idle, 1 run, 2 halt
    logic [1:0]  m_err;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_base(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h3e80_2403;
        if (a == 32'h0040_0004) return 32'h3ec0_2483;
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_1234;
    endfunction

    always_comb imem_rdata = (imem_addr == err_addr) ? ERRW : rom_base(imem_addr);

    fetch_ctrl #(.RESET_PC(RPC), .DEPTH(DEPTH), .ERR_WORD(ERRW)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .halted(halted), .err_code(err_code)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic fe, input logic rv,
                                input logic [31:0] rpc, input logic rdy);
        int          orig;
        logic [31:0] w;
        if (r) begin
            mq.delete(); m_pc = RPC; m_st = 0; m_err = 2'd0;
            return;
        end
        orig = m_st;
        if (rv) begin
            mq.delete();
            if (rpc[1:0] == 2'b00) begin
                m_pc = rpc; m_err = 2'd0;
                if (orig != 0) m_st = 1;
            end else begin
                m_st = 2; m_err = 2'd2;
            end
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (orig == 1) begin
                if (mq.size() < DEPTH) begin
                    w = (m_pc == err_addr) ? ERRW : rom_base(m_pc);
                    if (w == ERRW) begin
                        m_st = 2; m_err = 2'd1;
                    end else begin
                        mq.push_back({m_pc, w});
                        m_pc = m_pc + 32'd4;
                    end
                end
                if (m_st == 1 && !fe) m_st = 0;
            end else if (orig == 0 && fe) begin
                m_st = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_addr", {32'd0, imem_addr}, {32'd0, m_pc});
        chk("inst_valid", {63'd0, inst_valid}, {63'd0, (mq.size() != 0)});
        chk("halted", {63'd0, halted}, {63'd0, (m_st == 2)});
        chk("err_code", {62'd0, err_code}, {62'd0, m_err});
        if (mq.size() != 0) begin
            chk("inst", {32'd0, inst}, {32'd0, mq[0][31:0]});
            chk("inst_pc", {32'd0, inst_pc}, {32'd0, mq[0][63:32]});
        end
    endtask

    task automatic step(input logic r, input logic fe, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        rst = r; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
        model_update(r, fe, rv, rpc, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] pc_before;
        logic [31:0] rpc_r;
        // reset state
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("reset_addr", {32'd0, imem_addr}, {32'd0, RPC});
        chk("reset_inst", {32'd0, inst}, 64'd0);
        chk("reset_inst_pc", {32'd0, inst_pc}, 64'd0);
        // basic streaming: enter RUN, first word visible one cycle later
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("first_inst", {32'd0, inst}, {32'd0, 32'h3e80_2403});
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("second_inst", {32'd0, inst}, {32'd0, 32'h3ec0_2483});
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        // back-pressure: fill the queue and freeze the PC
        step(1'b0, 1'b1, 1'b1, RPC, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("stall_pc", {32'd0, imem_addr}, {32'd0, 32'h0040_0008});
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        // redirect on a full queue with a simultaneous pop
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, RPC, 1'b1);
        chk("flush_valid", {63'd0, inst_valid}, 64'd0);
        chk("flush_addr", {32'd0, imem_addr}, {32'd0, RPC});
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("post_flush_pc", {32'd0, inst_pc}, {32'd0, RPC});
        // unmapped word at 0x00400020 with one older entry still queued
        err_addr = RPC + 32'h20;
        step(1'b0, 1'b1, 1'b1, RPC, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("unmapped_halted", {63'd0, halted}, 64'd1);
        chk("unmapped_err", {62'd0, err_code}, 64'd1);
        chk("unmapped_addr", {32'd0, imem_addr}, {32'd0, RPC + 32'h20});
        chk("unmapped_drain", {63'd0, inst_valid}, 64'd1);
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("unmapped_empty", {63'd0, inst_valid}, 64'd0);
        step(1'b0, 1'b1, 1'b1, RPC, 1'b1);
        chk("recover_err", {62'd0, err_code}, 64'd0);
        err_addr = 32'h0000_0001;
        // misaligned redirect
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        pc_before = m_pc;
        step(1'b0, 1'b1, 1'b1, 32'h0040_0006, 1'b0);
        chk("misalign_err", {62'd0, err_code}, 64'd2);
        chk("misalign_pc", {32'd0, imem_addr}, {32'd0, pc_before});
        chk("misalign_valid", {63'd0, inst_valid}, 64'd0);
        // reset overriding a full queue and a pending redirect
        step(1'b0, 1'b1, 1'b1, RPC, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h0040_0100, 1'b1);
        chk("rst_addr", {32'd0, imem_addr}, {32'd0, RPC});
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        // PC wrap-around at the top of the address space
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0)
                err_addr = ($urandom_range(0, 1) == 0) ? 32'h0000_0001
                                                       : RPC + 32'($urandom_range(0, 63)) * 32'd4;
            rpc_r = RPC + 32'($urandom_range(0, 63)) * 32'd4;
            if ($urandom_range(0, 9) == 0) rpc_r = rpc_r + 32'($urandom_range(1, 3));
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 11) == 0), rpc_r, ($urandom_range(0, 2) != 0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
